// File: rtl/mm_incr_ctrl.sv
// mm_incr_ctrl: Avalon-MM read-modify-write engine. For each word of a job it
// reads base+k, adds one to every masked byte lane, and writes the word back.
// Bus outputs are decoded from the state and from registered job/word data.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no job; waits for start_i
// RD_REQ  | read request for word k held on the bus until accepted
// RD_WAIT | read accepted; waits for readdatavalid, captures modified word
// WR_REQ  | write request for word k held on the bus until accepted
// DONE    | one-cycle done_o pulse, then back to IDLE
module mm_incr_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 11,
  localparam int BYTE_CNT  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic [BYTE_CNT-1:0]   first_be_i,
  input  logic [BYTE_CNT-1:0]   last_be_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  input  logic [DATA_WIDTH-1:0] readdata,
  input  logic                  readdatavalid,
  input  logic                  waitrequest,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic [BYTE_CNT-1:0]   byteenable
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  k;
  logic [BYTE_CNT-1:0]   first_be_q;
  logic [BYTE_CNT-1:0]   last_be_q;
  logic [BYTE_CNT-1:0]   word_mask;
  logic [DATA_WIDTH-1:0] word_mod;
  logic                  accept_start;
  logic                  last_word;
  logic                  wr_accept;

  assign accept_start = (state == IDLE) && start_i && (length_i != '0);
  assign last_word    = (k == len_q - LEN_WIDTH'(1));
  assign wr_accept    = (state == WR_REQ) && !waitrequest;

  // Request strobes and status come straight from the state, so reset clears them at once.
  assign read   = (state == RD_REQ);
  assign write  = (state == WR_REQ);
  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  // base_q and k only move on job start and write acceptance, so the address
  // holds through stalls and idle periods; the sum wraps at the address width.
  assign address = base_q + ADDR_WIDTH'(k);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; readdatavalid only matters while a read is outstanding.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (length_i == '0) ? DONE : RD_REQ;
      RD_REQ:  if (!waitrequest) state_nxt = RD_WAIT;
      RD_WAIT: if (readdatavalid) state_nxt = WR_REQ;
      WR_REQ:  if (!waitrequest) state_nxt = last_word ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters are captured only when a non-empty job is accepted from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      len_q      <= '0;
      first_be_q <= '0;
      last_be_q  <= '0;
    end else if (accept_start) begin
      base_q     <= base_i;
      len_q      <= length_i;
      first_be_q <= first_be_i;
      last_be_q  <= last_be_i;
    end
  end

  // Word index; it stays on the final word so the address does not move after the job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           k <= '0;
    else if (accept_start)             k <= '0;
    else if (wr_accept && !last_word)  k <= k + LEN_WIDTH'(1);
  end

  // Byte mask for the current word: edge masks on the first/last word, both on a single word.
  always_comb begin
    word_mask = '1;
    if (len_q == LEN_WIDTH'(1))  word_mask = first_be_q & last_be_q;
    else if (k == '0)            word_mask = first_be_q;
    else if (last_word)          word_mask = last_be_q;
  end

  // Per-lane increment of the returned word; unmasked lanes pass through.
  always_comb begin
    word_mod = readdata;
    for (int i = 0; i < BYTE_CNT; i++) begin
      if (word_mask[i]) word_mod[8*i +: 8] = readdata[8*i +: 8] + 8'd1;
    end
  end

  // Write payload is loaded once per word at read-data capture and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writedata  <= '0;
      byteenable <= '0;
    end else if ((state == RD_WAIT) && readdatavalid) begin
      writedata  <= word_mod;
      byteenable <= word_mask;
    end
  end

endmodule
